alu_arbiter: RTL and testbench

- Shares the single 8-bit ALU between two requesters, e.g. the instruction-execute path and a debug/DMA port.
- Round-robin arbitration between the two requesters.
- Registers the granted operands, sequences one ALU operation, and captures the result into result registers.
- Owns the architectural carry/zero flag registers, which update only on operations with WriteCZ set.

---
 rtl/alu_arbiter_if.sv | 55 +++++
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/grant, ALU and result bundle shared by the two requesters, the ALU and alu_arbiter.
// master: requesters plus the ALU datapath; slave: the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH_DATA_LENGTH   = 8,
  parameter int WIDTH_ALUSEL_LENGTH = 4
);
  logic                           Req0;
  logic [WIDTH_DATA_LENGTH-1:0]   DataA0;
  logic [WIDTH_DATA_LENGTH-1:0]   DataB0;
  logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel0;
  logic                           WriteCZ0;
  logic                           Gnt0;
  logic                           Done0;

  logic                           Req1;
  logic [WIDTH_DATA_LENGTH-1:0]   DataA1;
  logic [WIDTH_DATA_LENGTH-1:0]   DataB1;
  logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel1;
  logic                           WriteCZ1;
  logic                           Gnt1;
  logic                           Done1;

  logic [WIDTH_DATA_LENGTH-1:0]   AluDataA;
  logic [WIDTH_DATA_LENGTH-1:0]   AluDataB;
  logic [WIDTH_ALUSEL_LENGTH-1:0] AluSel;
  logic                           AluWriteCZ;
  logic [WIDTH_DATA_LENGTH-1:0]   AluDataOut;
  logic                           AluCF;
  logic                           AluZF;

  logic [WIDTH_DATA_LENGTH-1:0]   Result;
  logic                           ResultCF;
  logic                           ResultZF;
  logic                           FlagC;
  logic                           FlagZ;
  logic                           Busy;

  modport master (
    output Req0, DataA0, DataB0, ALUSel0, WriteCZ0,
    output Req1, DataA1, DataB1, ALUSel1, WriteCZ1,
    output AluDataOut, AluCF, AluZF,
    input  Gnt0, Done0, Gnt1, Done1,
    input  AluDataA, AluDataB, AluSel, AluWriteCZ,
    input  Result, ResultCF, ResultZF, FlagC, FlagZ, Busy
  );

  modport slave (
    input  Req0, DataA0, DataB0, ALUSel0, WriteCZ0,
    input  Req1, DataA1, DataB1, ALUSel1, WriteCZ1,
    input  AluDataOut, AluCF, AluZF,
    output Gnt0, Done0, Gnt1, Done1,
    output AluDataA, AluDataB, AluSel, AluWriteCZ,
    output Result, ResultCF, ResultZF, FlagC, FlagZ, Busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters; 3 cycles per op (grant, Gnt pulse, Done pulse).
// Requests are not accepted while Busy; a requester holds Req and operands until it sees Gnt.
module alu_arbiter #(
  parameter int WIDTH_DATA_LENGTH   = 8,
  parameter int WIDTH_ALUSEL_LENGTH = 4
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  typedef struct packed {
    logic [WIDTH_DATA_LENGTH-1:0]   dataA;
    logic [WIDTH_DATA_LENGTH-1:0]   dataB;
    logic [WIDTH_ALUSEL_LENGTH-1:0] aluSel;
    logic                           writeCZ;
  } operand_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t   state, stateNext;
  operand_t opReg, req0Op, req1Op;
  logic     lastGnt;
  logic     curSel;
  logic     grantValid;
  logic     grantSel;

  assign req0Op = {bus.DataA0, bus.DataB0, bus.ALUSel0, bus.WriteCZ0};
  assign req1Op = {bus.DataA1, bus.DataB1, bus.ALUSel1, bus.WriteCZ1};

  assign bus.AluDataA = opReg.dataA;
  assign bus.AluDataB = opReg.dataB;
  assign bus.AluSel   = opReg.aluSel;

  always_comb begin
    stateNext  = state;
    grantValid = 1'b0;
    grantSel   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Req0 || bus.Req1) begin
          grantValid = 1'b1;
          // On a tie the requester not served last time wins.
          grantSel   = (bus.Req0 && bus.Req1) ? ~lastGnt : bus.Req1;
          stateNext  = EXEC;
        end
      end
      EXEC:    stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      lastGnt        <= 1'b1;
      curSel         <= 1'b0;
      opReg          <= '0;
      bus.Gnt0       <= 1'b0;
      bus.Gnt1       <= 1'b0;
      bus.Done0      <= 1'b0;
      bus.Done1      <= 1'b0;
      bus.AluWriteCZ <= 1'b0;
      bus.Result     <= '0;
      bus.ResultCF   <= 1'b0;
      bus.ResultZF   <= 1'b0;
      bus.FlagC      <= 1'b0;
      bus.FlagZ      <= 1'b0;
      bus.Busy       <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (grantValid) begin
            opReg          <= grantSel ? req1Op : req0Op;
            lastGnt        <= grantSel;
            curSel         <= grantSel;
            bus.Gnt0       <= ~grantSel;
            bus.Gnt1       <= grantSel;
            bus.Busy       <= 1'b1;
            bus.AluWriteCZ <= grantSel ? bus.WriteCZ1 : bus.WriteCZ0;
          end
        end
        EXEC: begin
          bus.Result     <= bus.AluDataOut;
          bus.ResultCF   <= bus.AluCF;
          bus.ResultZF   <= bus.AluZF;
          if (opReg.writeCZ) begin
            bus.FlagC <= bus.AluCF;
            bus.FlagZ <= bus.AluZF;
          end
          bus.Gnt0       <= 1'b0;
          bus.Gnt1       <= 1'b0;
          bus.Done0      <= ~curSel;
          bus.Done1      <= curSel;
          bus.AluWriteCZ <= 1'b0;
        end
        RESP: begin
          bus.Done0 <= 1'b0;
          bus.Done1 <= 1'b0;
          bus.Busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural adder standing in for the ALU.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_if #(.WIDTH_DATA_LENGTH(8), .WIDTH_ALUSEL_LENGTH(4)) bus ();

  alu_arbiter #(.WIDTH_DATA_LENGTH(8), .WIDTH_ALUSEL_LENGTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [8:0] aluSum;
  assign aluSum         = {1'b0, bus.AluDataA} + {1'b0, bus.AluDataB};
  assign bus.AluDataOut = aluSum[7:0];
  assign bus.AluCF      = aluSum[8];
  assign bus.AluZF      = (aluSum[7:0] == 8'h00);

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [37:0] outsNow;
    rst = 1'b1;
    bus.Req0 = 1'b1; bus.Req1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      outsNow = {bus.Gnt0, bus.Gnt1, bus.Done0, bus.Done1, bus.AluDataA, bus.AluDataB,
                 bus.AluSel, bus.AluWriteCZ, bus.Result, bus.ResultCF, bus.ResultZF,
                 bus.FlagC, bus.FlagZ, bus.Busy};
      checks++;
      if (outsNow !== 38'h0) begin
        errors++; $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, outsNow);
      end
      checks++;
      if (bus.Busy !== 1'b0) begin
        errors++; $display("FAIL reset_busy cycle %0d: got %b expected 0", i, bus.Busy);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.Gnt1, bus.Gnt0} !== 2'b01) begin
      errors++; $display("FAIL first_grant: got Gnt1,Gnt0=%b expected 01", {bus.Gnt1, bus.Gnt0});
    end
  endtask

  // Entered in the EXEC cycle of the first tied grant (requester 0).
  task automatic test_round_robin;
    logic [2:0] order;
    int         nGrants;
    order = 3'b000;
    nGrants = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.Gnt0 && bus.Gnt1) begin
        errors++; $display("FAIL rr_gnt_overlap cycle %0d: both grants high", i);
      end
      checks++;
      if (bus.Done0 && bus.Done1) begin
        errors++; $display("FAIL rr_done_overlap cycle %0d: both dones high", i);
      end
      checks++;
      if (bus.Busy !== ((i % 3) != 1)) begin
        errors++; $display("FAIL rr_busy cycle %0d: got %b expected %b", i, bus.Busy, (i % 3) != 1);
      end
      if ((bus.Gnt0 || bus.Gnt1) && nGrants < 3) begin
        order[2 - nGrants] = bus.Gnt1;
        nGrants++;
      end
    end
    checks++;
    if (nGrants !== 3) begin
      errors++; $display("FAIL rr_grant_count: got %0d expected 3", nGrants);
    end
    checks++;
    if (order !== 3'b101) begin
      errors++; $display("FAIL rr_order (ops 2-4, 1=req1): got %b expected 101", order);
    end
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    tick();
  endtask

  task automatic test_single_req0;
    bus.Req0 = 1'b1; bus.DataA0 = 8'hFF; bus.DataB0 = 8'h01; bus.ALUSel0 = 4'h0; bus.WriteCZ0 = 1'b1;
    tick();
    checks++;
    if ({bus.Gnt0, bus.Gnt1, bus.Done0, bus.Busy} !== 4'b1001) begin
      errors++; $display("FAIL r0_grant: got Gnt0,Gnt1,Done0,Busy=%b expected 1001", {bus.Gnt0, bus.Gnt1, bus.Done0, bus.Busy});
    end
    checks++;
    if ({bus.AluDataA, bus.AluDataB, bus.AluWriteCZ} !== {8'hFF, 8'h01, 1'b1}) begin
      errors++; $display("FAIL r0_alu_in: got %h %h %b expected ff 01 1", bus.AluDataA, bus.AluDataB, bus.AluWriteCZ);
    end
    bus.Req0 = 1'b0; bus.DataA0 = 8'h55;
    tick();
    checks++;
    if ({bus.Done0, bus.Done1, bus.Gnt0} !== 3'b100) begin
      errors++; $display("FAIL r0_done: got Done0,Done1,Gnt0=%b expected 100", {bus.Done0, bus.Done1, bus.Gnt0});
    end
    checks++;
    if ({bus.Result, bus.ResultCF, bus.ResultZF} !== {8'h00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL r0_result: got %h cf=%b zf=%b expected 00 1 1", bus.Result, bus.ResultCF, bus.ResultZF);
    end
    checks++;
    if ({bus.FlagC, bus.FlagZ} !== 2'b11) begin
      errors++; $display("FAIL r0_flags: got %b expected 11", {bus.FlagC, bus.FlagZ});
    end
    checks++;
    if (bus.AluDataA !== 8'hFF) begin
      errors++; $display("FAIL r0_operand_hold: got %h expected ff", bus.AluDataA);
    end
    tick();
    checks++;
    if ({bus.Done0, bus.Busy} !== 2'b00) begin
      errors++; $display("FAIL r0_idle: got Done0,Busy=%b expected 00", {bus.Done0, bus.Busy});
    end
  endtask

  task automatic test_single_req1;
    bus.Req1 = 1'b1; bus.DataA1 = 8'h10; bus.DataB1 = 8'h20; bus.ALUSel1 = 4'h0; bus.WriteCZ1 = 1'b0;
    tick();
    checks++;
    if ({bus.Gnt1, bus.Gnt0, bus.AluWriteCZ} !== 3'b100) begin
      errors++; $display("FAIL r1_grant: got Gnt1,Gnt0,AluWriteCZ=%b expected 100", {bus.Gnt1, bus.Gnt0, bus.AluWriteCZ});
    end
    bus.Req1 = 1'b0;
    tick();
    checks++;
    if ({bus.Done1, bus.Done0} !== 2'b10) begin
      errors++; $display("FAIL r1_done: got Done1,Done0=%b expected 10", {bus.Done1, bus.Done0});
    end
    checks++;
    if ({bus.Result, bus.ResultCF, bus.ResultZF} !== {8'h30, 1'b0, 1'b0}) begin
      errors++; $display("FAIL r1_result: got %h cf=%b zf=%b expected 30 0 0", bus.Result, bus.ResultCF, bus.ResultZF);
    end
    checks++;
    if ({bus.FlagC, bus.FlagZ} !== 2'b11) begin
      errors++; $display("FAIL r1_flags_hold: got %b expected 11", {bus.FlagC, bus.FlagZ});
    end
    tick();
  endtask

  task automatic test_alusel;
    bus.Req1 = 1'b1; bus.DataA1 = 8'hFF; bus.DataB1 = 8'h02; bus.ALUSel1 = 4'hA; bus.WriteCZ1 = 1'b1;
    checks++;
    if (bus.AluWriteCZ !== 1'b0) begin
      errors++; $display("FAIL sel_wcz_idle: got %b expected 0", bus.AluWriteCZ);
    end
    tick();
    checks++;
    if ({bus.AluSel, bus.AluWriteCZ} !== {4'hA, 1'b1}) begin
      errors++; $display("FAIL sel_exec: got sel=%h wcz=%b expected a 1", bus.AluSel, bus.AluWriteCZ);
    end
    bus.Req1 = 1'b0;
    tick();
    checks++;
    if (bus.AluWriteCZ !== 1'b0) begin
      errors++; $display("FAIL sel_wcz_resp: got %b expected 0", bus.AluWriteCZ);
    end
    checks++;
    if ({bus.Result, bus.FlagC, bus.FlagZ} !== {8'h01, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sel_result_flags: got %h C=%b Z=%b expected 01 1 0", bus.Result, bus.FlagC, bus.FlagZ);
    end
    tick();
    checks++;
    if ({bus.AluSel, bus.AluWriteCZ} !== {4'hA, 1'b0}) begin
      errors++; $display("FAIL sel_idle_hold: got sel=%h wcz=%b expected a 0", bus.AluSel, bus.AluWriteCZ);
    end
  endtask

  task automatic test_reset_midop;
    bus.Req0 = 1'b1; bus.DataA0 = 8'h80; bus.DataB0 = 8'h80; bus.WriteCZ0 = 1'b1;
    tick();
    checks++;
    if (bus.Gnt0 !== 1'b1) begin
      errors++; $display("FAIL mid_grant: got %b expected 1", bus.Gnt0);
    end
    bus.Req0 = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.Done0, bus.Gnt0, bus.Busy} !== 3'b000) begin
      errors++; $display("FAIL mid_abort: got Done0,Gnt0,Busy=%b expected 000", {bus.Done0, bus.Gnt0, bus.Busy});
    end
    checks++;
    if ({bus.Result, bus.FlagC, bus.FlagZ} !== 10'h000) begin
      errors++; $display("FAIL mid_cleared: got %h C=%b Z=%b expected 00 0 0", bus.Result, bus.FlagC, bus.FlagZ);
    end
    rst = 1'b0;
    bus.Req0 = 1'b1; bus.Req1 = 1'b1;
    tick();
    checks++;
    if ({bus.Gnt1, bus.Gnt0} !== 2'b01) begin
      errors++; $display("FAIL mid_regrant: got Gnt1,Gnt0=%b expected 01", {bus.Gnt1, bus.Gnt0});
    end
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    tick();
    checks++;
    if ({bus.Done0, bus.Done1, bus.Result, bus.FlagC, bus.FlagZ} !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL mid_done: got D0=%b D1=%b res=%h C=%b Z=%b expected 1 0 00 1 1",
                         bus.Done0, bus.Done1, bus.Result, bus.FlagC, bus.FlagZ);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.Req0 = 1'b0; bus.DataA0 = 8'h00; bus.DataB0 = 8'h00; bus.ALUSel0 = 4'h0; bus.WriteCZ0 = 1'b0;
    bus.Req1 = 1'b0; bus.DataA1 = 8'h00; bus.DataB1 = 8'h00; bus.ALUSel1 = 4'h0; bus.WriteCZ1 = 1'b0;
    test_reset();
    test_round_robin();
    test_single_req0();
    test_single_req1();
    test_alusel();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
